pmci_vdm_tx_seq: RTL

Sequencer that sends one host-side MCTP-over-VDM message through the PMCI VDM mailbox as a multi-packet transfer. It splits a message of up to `DW_PER_PKT*MAX_PKTS` dwords into packets and writes each packet's payload to the packet data register (PDR). It then commits each packet through the flow control register (FCR), polling FCR busy before every packet. It sits between a message-source FIFO and the CSR master port toward the PMCI feature (`PMCI_VDM_FCR` = 0x82000, `PMCI_VDM_PDR` = 0x82008).

---
 rtl/pmci_vdm_pkg.sv | 37 +++
 rtl/pmci_vdm_csr_if.sv | 40 ++++
 rtl/pmci_vdm_tx_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pmci_vdm_pkg.sv
// Shared definitions for the PMCI VDM mailbox transmit sequencer:
// FCR field layout, sequencer states and error codes.
package pmci_vdm_pkg;

    localparam int FCR_BUSY    = 0;
    localparam int FCR_GO      = 0;
    localparam int FCR_SOM     = 1;
    localparam int FCR_EOM     = 2;
    localparam int FCR_SEQ_LSB = 8;
    localparam int FCR_CNT_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        POLL_RD,
        DATA_WR,
        CMD_WR,
        DRAIN,
        FIN
    } vdm_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    function automatic logic [31:0] fcr_cmd(input logic som, input logic eom,
                                            input logic [1:0] seq, input logic [9:0] cnt);
        logic [31:0] w;
        w = '0;
        w[FCR_GO]              = 1'b1;
        w[FCR_SOM]             = som;
        w[FCR_EOM]             = eom;
        w[FCR_SEQ_LSB +: 2]    = seq;
        w[FCR_CNT_LSB +: 10]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/pmci_vdm_csr_if.sv
// Single-outstanding CSR master stage: registers a read or write request and
// holds strobe/address/data until the access is acknowledged.
module pmci_vdm_csr_if (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_wr,
    input  logic        issue_rd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        csr_ack,
    output logic        csr_wr,
    output logic        csr_rd,
    output logic [31:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        pending,
    output logic        acked
);

    assign pending = csr_wr | csr_rd;
    // An ack with no access in flight is ignored.
    assign acked   = pending & csr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_wr    <= 1'b0;
            csr_rd    <= 1'b0;
            csr_addr  <= '0;
            csr_wdata <= '0;
        end else if (issue_wr | issue_rd) begin
            csr_wr    <= issue_wr;
            csr_rd    <= issue_rd;
            csr_addr  <= addr;
            csr_wdata <= wdata;
        end else if (acked) begin
            csr_wr    <= 1'b0;
            csr_rd    <= 1'b0;
        end
    end

endmodule

// File: rtl/pmci_vdm_tx_seq.sv
// Sends one MCTP-over-VDM message through the PMCI mailbox as a sequence of
// packets: poll FCR busy, write payload to PDR, commit packet via FCR.
module pmci_vdm_tx_seq
    import pmci_vdm_pkg::*;
#(
    parameter int          DW_PER_PKT = 16,
    parameter int          MAX_PKTS   = 8,
    parameter logic [31:0] FCR_ADDR   = 32'h0008_2000,
    parameter logic [31:0] PDR_ADDR   = 32'h0008_2008,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_len_dw,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        csr_wr,
    output logic        csr_rd,
    output logic [31:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic        csr_ack,
    input  logic [31:0] csr_rdata,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int PKW     = $clog2(DW_PER_PKT) + 1;
    localparam int PCW     = $clog2(POLL_LIMIT);
    localparam int MAX_LEN = DW_PER_PKT * MAX_PKTS;

    vdm_state_e     state;
    logic [9:0]     remaining;
    logic [9:0]     pkt_idx;
    logic [PKW-1:0] pkt_dw;
    logic [PKW-1:0] pkt_cnt;
    logic [PCW-1:0] poll_cnt;
    logic [1:0]     seq;

    logic           issue_wr, issue_rd;
    logic [31:0]    issue_addr, issue_wdata;
    logic           pending, acked;

    logic           accept, bad_len, fcr_busy, poll_last, din_fire;
    logic [PKW-1:0] pkt_size;
    logic           unused_rdata;

    assign unused_rdata = ^csr_rdata[31:1];

    assign req_ready = (state == IDLE);
    assign din_ready = ((state == DATA_WR) && !pending) || (state == DRAIN);
    assign accept    = req_valid & req_ready;
    assign din_fire  = din_valid & din_ready;
    assign bad_len   = (req_len_dw == 10'd0) || (int'(req_len_dw) > MAX_LEN);
    assign fcr_busy  = csr_rdata[FCR_BUSY];
    assign poll_last = (poll_cnt == PCW'(POLL_LIMIT - 1));
    assign pkt_size  = (int'(remaining) > DW_PER_PKT) ? PKW'(DW_PER_PKT) : PKW'(remaining);

    // Next access is launched in the cycle of the previous ack so the strobe
    // can stay high back-to-back.
    always_comb begin
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        issue_addr  = FCR_ADDR;
        issue_wdata = '0;
        case (state)
            IDLE:    issue_rd = accept && !bad_len;
            POLL_RD: issue_rd = acked && fcr_busy && !poll_last;
            DATA_WR: begin
                if (din_fire) begin
                    issue_wr    = 1'b1;
                    issue_addr  = PDR_ADDR;
                    issue_wdata = din_data;
                end else if (acked && pkt_dw == PKW'(1)) begin
                    issue_wr    = 1'b1;
                    issue_wdata = fcr_cmd(pkt_idx == 10'd0, remaining == 10'd1,
                                          seq, 10'(pkt_cnt));
                end
            end
            CMD_WR:  issue_rd = acked && (remaining != 10'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            pkt_idx   <= '0;
            pkt_dw    <= '0;
            pkt_cnt   <= '0;
            poll_cnt  <= '0;
            seq       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    remaining <= req_len_dw;
                    pkt_idx   <= '0;
                    seq       <= '0;
                    poll_cnt  <= '0;
                    if (bad_len) begin
                        err_code <= ERR_LEN;
                        err      <= 1'b1;
                        state    <= FIN;
                    end else begin
                        err_code <= ERR_NONE;
                        state    <= POLL_RD;
                    end
                end
                POLL_RD: if (acked) begin
                    if (!fcr_busy) begin
                        poll_cnt <= '0;
                        pkt_dw   <= pkt_size;
                        pkt_cnt  <= pkt_size;
                        state    <= DATA_WR;
                    end else if (poll_last) begin
                        err_code <= ERR_TMO;
                        state    <= DRAIN;
                    end else begin
                        poll_cnt <= poll_cnt + PCW'(1);
                    end
                end
                DATA_WR: if (acked) begin
                    pkt_dw    <= pkt_dw - PKW'(1);
                    remaining <= remaining - 10'd1;
                    if (pkt_dw == PKW'(1)) state <= CMD_WR;
                end
                CMD_WR: if (acked) begin
                    seq     <= seq + 2'd1;
                    pkt_idx <= pkt_idx + 10'd1;
                    if (remaining == 10'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        state <= POLL_RD;
                    end
                end
                // Consume the rest of the message so the source FIFO stays aligned.
                DRAIN: if (din_fire) begin
                    remaining <= remaining - 10'd1;
                    if (remaining == 10'd1) begin
                        err   <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pmci_vdm_csr_if u_csr (
        .clk       (clk),
        .rst       (rst),
        .issue_wr  (issue_wr),
        .issue_rd  (issue_rd),
        .addr      (issue_addr),
        .wdata     (issue_wdata),
        .csr_ack   (csr_ack),
        .csr_wr    (csr_wr),
        .csr_rd    (csr_rd),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .pending   (pending),
        .acked     (acked)
    );

endmodule
